// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch (M:SS.t) with run/hold, synchronous clear and lap freeze.
// Digit outputs feed the seven-segment decoders; the lap snapshot is selected while frozen.
module stopwatch_bcd #(
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned PW       = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       clr,
  input  logic       lap,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       lap_active,
  output logic       wrap
);

  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] NINE = DW'(9);
  localparam logic [DW-1:0] FIVE = DW'(5);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] live0_q, live0_d, live1_q, live1_d;
  logic [DW-1:0] live2_q, live2_d, live3_q, live3_d;
  logic [DW-1:0] snap0_q, snap0_d, snap1_q, snap1_d;
  logic [DW-1:0] snap2_q, snap2_d, snap3_q, snap3_d;
  logic          lap_active_q, lap_active_d;
  logic          wrap_q, wrap_d;
  logic          lap_prev_q, lap_prev_d;

  logic tick;
  logic carry0, carry1, carry2, carry3;
  logic lap_edge;

  // Prescaler, digit cascade, lap toggle and clear priority.
  always_comb begin
    presc_d      = presc_q;
    live0_d      = live0_q;
    live1_d      = live1_q;
    live2_d      = live2_q;
    live3_d      = live3_q;
    snap0_d      = snap0_q;
    snap1_d      = snap1_q;
    snap2_d      = snap2_q;
    snap3_d      = snap3_q;
    lap_active_d = lap_active_q;
    wrap_d       = 1'b0;
    lap_prev_d   = lap;

    tick     = go && (presc_q == PRESC_LAST);
    lap_edge = lap && !lap_prev_q;

    // All carries resolve combinationally so the whole count advances on one edge.
    carry0 = tick   && (live0_q >= NINE);
    carry1 = carry0 && (live1_q >= NINE);
    carry2 = carry1 && (live2_q >= FIVE);
    carry3 = carry2 && (live3_q >= NINE);

    if (go) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (tick) begin
      live0_d = carry0 ? '0 : live0_q + DW'(1);
    end
    if (carry0) begin
      live1_d = carry1 ? '0 : live1_q + DW'(1);
    end
    if (carry1) begin
      live2_d = carry2 ? '0 : live2_q + DW'(1);
    end
    if (carry2) begin
      live3_d = carry3 ? '0 : live3_q + DW'(1);
    end
    wrap_d = carry3;

    // Snapshot captures the pre-tick live value so a coincident tick is not shown.
    if (lap_edge) begin
      if (!lap_active_q) begin
        snap0_d      = live0_q;
        snap1_d      = live1_q;
        snap2_d      = live2_q;
        snap3_d      = live3_q;
        lap_active_d = 1'b1;
      end else begin
        lap_active_d = 1'b0;
      end
    end

    if (clr) begin
      presc_d      = '0;
      live0_d      = '0;
      live1_d      = '0;
      live2_d      = '0;
      live3_d      = '0;
      snap0_d      = '0;
      snap1_d      = '0;
      snap2_d      = '0;
      snap3_d      = '0;
      lap_active_d = 1'b0;
      wrap_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      live0_q      <= '0;
      live1_q      <= '0;
      live2_q      <= '0;
      live3_q      <= '0;
      snap0_q      <= '0;
      snap1_q      <= '0;
      snap2_q      <= '0;
      snap3_q      <= '0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
      lap_prev_q   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      live0_q      <= live0_d;
      live1_q      <= live1_d;
      live2_q      <= live2_d;
      live3_q      <= live3_d;
      snap0_q      <= snap0_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      snap3_q      <= snap3_d;
      lap_active_q <= lap_active_d;
      wrap_q       <= wrap_d;
      lap_prev_q   <= lap_prev_d;
    end
  end

  // Display select is driven only by registers.
  assign d0         = lap_active_q ? snap0_q : live0_q;
  assign d1         = lap_active_q ? snap1_q : live1_q;
  assign d2         = lap_active_q ? snap2_q : live2_q;
  assign d3         = lap_active_q ? snap3_q : live3_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Randomized self-checking bench for stopwatch_bcd against a tenths-count reference model.
module tb_stopwatch_bcd;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic go = 1'b0;
  logic clr = 1'b0;
  logic lap = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic lap_active, wrap;
  logic [17:0] act;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: elapsed time as a plain count of tenths.
  int m_cnt, m_presc, m_snap;
  bit m_lap, m_prev, m_wrap;

  stopwatch_bcd #(.TICK_DIV(TD), .PW(23)) dut (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .lap(lap),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .lap_active(lap_active), .wrap(wrap)
  );

  always #5 clk = ~clk;

  assign act = {d3, d2, d1, d0, lap_active, wrap};

  function automatic void model_reset();
    m_cnt = 0; m_presc = 0; m_snap = 0;
    m_lap = 1'b0; m_prev = 1'b0; m_wrap = 1'b0;
  endfunction

  function automatic void model_step();
    int old;
    bit tk;
    old = m_cnt;
    tk = go && (m_presc == int'(TD) - 1);
    if (clr) begin
      m_cnt = 0; m_presc = 0; m_snap = 0; m_lap = 1'b0; m_wrap = 1'b0;
    end else begin
      m_wrap = tk && (old == 5999);
      if (tk) m_cnt = (old + 1) % 6000;
      if (go) m_presc = tk ? 0 : m_presc + 1;
      if (lap && !m_prev) begin
        if (!m_lap) begin
          m_snap = old;
          m_lap = 1'b1;
        end else begin
          m_lap = 1'b0;
        end
      end
    end
    m_prev = lap;
  endfunction

  function automatic logic [17:0] exp_vec();
    int t;
    t = m_lap ? m_snap : m_cnt;
    return {4'(t / 600), 4'((t % 600) / 100), 4'((t % 100) / 10), 4'(t % 10), m_lap, m_wrap};
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_reset();
    go = 1'b0; clr = 1'b0; lap = 1'b0;
    reset = 1'b1;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    go = 1'b1; clr = 1'b0; lap = 1'b0;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if (act !== 18'h0) begin
        miscompares++;
        $display("FAIL reset_held act=%h exp=%h", act, 18'h0);
      end
    end
    reset = 1'b0;
    cycle();
    vectors++;
    if (act !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_release act=%h exp=%h", act, 18'h0);
    end
  endtask

  task automatic test_count();
    do_reset();
    go = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL count edge=%0d act=%h exp=%h", i, act, exp_vec());
      end
      if (i == 3 || i == 4) begin
        vectors++;
        if (d0 !== 4'(i / 4)) begin
          miscompares++;
          $display("FAIL count_latency edge=%0d d0=%0d exp=%0d", i, d0, i / 4);
        end
      end
    end
    vectors++;
    if ({d3, d2, d1, d0, wrap} !== {16'h0010, 1'b0}) begin
      miscompares++;
      $display("FAIL count_1s act=%h exp=%h", {d3, d2, d1, d0, wrap}, {16'h0010, 1'b0});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    go = 1'b1;
    for (int i = 1; i <= 23996; i++) begin
      cycle();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap_run edge=%0d act=%h exp=%h", i, act, exp_vec());
      end
    end
    vectors++;
    if ({d3, d2, d1, d0, wrap} !== {16'h9599, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_top act=%h exp=%h", {d3, d2, d1, d0, wrap}, {16'h9599, 1'b0});
    end
    for (int i = 1; i <= 4; i++) begin
      cycle();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap_edge edge=%0d act=%h exp=%h", i, act, exp_vec());
      end
    end
    vectors++;
    if ({d3, d2, d1, d0, wrap} !== {16'h0000, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_pulse act=%h exp=%h", {d3, d2, d1, d0, wrap}, {16'h0000, 1'b1});
    end
    cycle();
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_single act=%b exp=0", wrap);
    end
  endtask

  task automatic test_hold();
    do_reset();
    go = 1'b1;
    repeat (6) cycle();
    go = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      vectors++;
      if (d0 !== 4'd1) begin
        miscompares++;
        $display("FAIL hold_freeze cyc=%0d d0=%0d exp=1", i, d0);
      end
    end
    go = 1'b1;
    cycle();
    vectors++;
    if (d0 !== 4'd1) begin
      miscompares++;
      $display("FAIL hold_resume1 d0=%0d exp=1", d0);
    end
    cycle();
    vectors++;
    if (d0 !== 4'd2) begin
      miscompares++;
      $display("FAIL hold_resume2 d0=%0d exp=2", d0);
    end
    // Randomized run/hold lengths against the model.
    for (int r = 0; r < 4; r++) begin
      int run_len, hold_len;
      run_len = int'($urandom_range(1, 15));
      hold_len = int'($urandom_range(1, 25));
      go = 1'b1;
      for (int i = 0; i < run_len + hold_len; i++) begin
        if (i == run_len) go = 1'b0;
        cycle();
        vectors++;
        if (act !== exp_vec()) begin
          miscompares++;
          $display("FAIL hold_rand r=%0d i=%0d act=%h exp=%h", r, i, act, exp_vec());
        end
      end
    end
  endtask

  task automatic test_lap();
    do_reset();
    go = 1'b1;
    repeat (20) cycle();
    lap = 1'b1;
    cycle();
    lap = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL lap_model i=%0d act=%h exp=%h", i, act, exp_vec());
      end
    end
    vectors++;
    if ({d3, d2, d1, d0, lap_active} !== {16'h0005, 1'b1}) begin
      miscompares++;
      $display("FAIL lap_frozen act=%h exp=%h", {d3, d2, d1, d0, lap_active}, {16'h0005, 1'b1});
    end
    lap = 1'b1;
    cycle();
    lap = 1'b0;
    vectors++;
    if ({d3, d2, d1, d0, lap_active} !== {16'h0008, 1'b0}) begin
      miscompares++;
      $display("FAIL lap_release act=%h exp=%h", {d3, d2, d1, d0, lap_active}, {16'h0008, 1'b0});
    end
  endtask

  task automatic test_clr_priority();
    do_reset();
    go = 1'b1;
    repeat (7) cycle();
    clr = 1'b1;
    lap = 1'b1;
    cycle();
    clr = 1'b0;
    vectors++;
    if (act !== 18'h0) begin
      miscompares++;
      $display("FAIL clr_prio act=%h exp=%h", act, 18'h0);
    end
    lap = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      vectors++;
      if (d0 !== 4'(i / 4)) begin
        miscompares++;
        $display("FAIL clr_restart edge=%0d d0=%0d exp=%0d", i, d0, i / 4);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    go = 1'b1;
    for (int i = 1; i <= 148; i++) begin
      lap = (i == 146);
      cycle();
    end
    lap = 1'b0;
    vectors++;
    if ({lap_active, exp_vec()} !== {1'b1, act}) begin
      miscompares++;
      $display("FAIL areset_pre act=%h exp=%h lap_active=%b", act, exp_vec(), lap_active);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (act !== 18'h0) begin
      miscompares++;
      $display("FAIL areset_mid act=%h exp=%h", act, 18'h0);
    end
    cycle();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL areset_resume edge=%0d act=%h exp=%h", i, act, exp_vec());
      end
    end
    vectors++;
    if (d0 !== 4'd1) begin
      miscompares++;
      $display("FAIL areset_d0 d0=%0d exp=1", d0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      go = ($urandom % 4) != 0;
      if ($urandom % 8 == 0) lap = ~lap;
      clr = ($urandom % 60) == 0;
      if ($urandom % 500 == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      cycle();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL random i=%0d act=%h exp=%h", i, act, exp_vec());
      end
    end
    reset = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_count();
    test_wrap();
    test_hold();
    test_lap();
    test_clr_priority();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Four-digit BCD stopwatch counter in M:SS.t format, digits d3..d0 = minutes, tens of seconds, seconds, tenths.
- Sits directly upstream of the hex-to-seven-segment decoders and the four-digit display multiplexer.
- Each digit output feeds one decoder hex input.
- Provides run/hold, synchronous clear and a lap (display freeze) function.

Parameters:
- TICK_DIV, 5000000, clk cycles per 0.1 s tick (50 MHz clk); must be >= 2; set to 4 in simulation.
- PW, 23, prescaler width; must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- go  input  1  level; 1 = count, 0 = hold.
- clr  input  1  synchronous clear, sampled on clk.
- lap  input  1  level, already debounced; each rising edge toggles lap mode.
- d0  output  4  tenths digit, 0-9.
- d1  output  4  seconds digit, 0-9.
- d2  output  4  tens-of-seconds digit, 0-5.
- d3  output  4  minutes digit, 0-9.
- lap_active  output  1  1 while the displayed value is frozen.
- wrap  output  1  one-cycle pulse when the count rolls 9:59.9 -> 0:00.0.

Behaviour:
- Reset (async, active-high):
  - prescaler, live digits, snapshot digits, lap_active, wrap and the lap edge-detect register all go to 0.
  - Outputs read 0:00.0 while reset is high and in the cycle after it deasserts.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while go=1.
  - tick is asserted internally in the cycle where prescaler = TICK_DIV-1 and go=1; the prescaler returns to 0 on that edge.
  - go=0 freezes the prescaler at its current value, with no reset to 0. Counting resumes from that value when go returns to 1.
- Digit cascade, updated on the tick edge only:
  - d0 increments; at 9 it goes to 0 and carries into d1.
  - d1: 9 -> 0 carries into d2.
  - d2: 5 -> 0 carries into d3.
  - d3: 9 -> 0 means full wrap to 0:00.0.
  - All carries resolve in the same edge, with no ripple latency.
  - Digits never leave their legal range.
- wrap:
  - Registered. It is 1 for exactly one cycle, the cycle after the edge on which 9:59.9 became 0:00.0.
  - It is 0 otherwise, including when clr forces 0:00.0.
- Counting latency: with go held at 1 from a prescaler of 0, d0 changes after TICK_DIV rising edges.
- clr (synchronous):
  - On the next edge, prescaler, live digits and snapshot go to 0, lap_active goes to 0 and wrap to 0.
  - clr has priority over a tick and over a lap edge on the same edge.
  - go is not affected; counting restarts from 0 if go=1.
- Lap:
  - The lap rising edge is detected with a registered copy of lap.
  - On a detected edge with lap_active=0: lap_active goes to 1 and the snapshot loads the live digits as they were before this edge's tick update. If a tick occurs on the same edge, the snapshot holds the pre-increment value.
  - On a detected edge with lap_active=1: lap_active goes to 0.
  - The live count continues throughout lap mode.
- Output mux:
  - d3..d0 = snapshot when lap_active=1, otherwise live digits.
  - Combinational from registers only; no combinational path from inputs to outputs.
- Reset mid-operation: any state, including lap mode or mid-prescale, returns to the reset values immediately.

Test Plan (TICK_DIV=4):
1. Counting: reset for 2 cycles, then go=1 for 40 cycles -> d0=1 after the 4th edge; 0:01.0 (d1=1, d0=0) after the 40th edge; wrap stays 0.
2. Full wrap: go=1 for 23996 cycles -> 9:59.9. After 4 more edges -> 0:00.0, with wrap=1 for exactly one cycle and 0 on the next.
3. Hold: go=1 for 6 cycles, go=0 for 20 cycles, go=1 again -> d0 stays 1 during the hold and becomes 2 exactly 2 edges after go returns to 1 (prescaler resumed from 2).
4. Lap: count to 0:00.5, pulse lap, run 12 more cycles -> outputs hold 0:00.5 with lap_active=1. Pulse lap again -> outputs show live 0:00.8, lap_active=0.
5. clr priority: assert clr in the cycle where a tick and a lap edge coincide -> next cycle shows 0:00.0, lap_active=0, wrap=0, prescaler=0.
6. Async reset mid-count: assert reset at 0:03.7 with lap_active=1, between clock edges -> outputs read 0:00.0 and lap_active=0 before the next edge; counting resumes normally after release.
